// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: row returns in, column drives and key-event outputs.
// The master side is the keypad/consumer; the slave side is the scanner itself.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic       keyhit;
    logic [3:0] keycode;
    logic       key_down;

    modport master (
        output row,
        input  col,
        input  keyhit,
        input  keycode,
        input  key_down
    );

    modport slave (
        input  row,
        output col,
        output keyhit,
        output keycode,
        output key_down
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the active-low columns, synchronizes and
// debounces the row returns, and reports one keyhit pulse per physical press.
module keypad_scanner #(
    parameter int SCAN_CYCLES      = 50000,
    parameter int DEBOUNCE_SAMPLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scanner_if.slave  kp
);

    localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int SW = $clog2(DEBOUNCE_SAMPLES + 1);

    localparam logic [DW-1:0] DWELL_LAST    = DW'(SCAN_CYCLES - 1);
    // Value of the stable counter on the sample that completes the required run.
    localparam logic [SW-1:0] STABLE_ACCEPT = SW'(DEBOUNCE_SAMPLES - 1);
    localparam logic [SW-1:0] STABLE_MAX    = SW'(DEBOUNCE_SAMPLES);

    localparam logic [1:0] S_SCAN     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_PRESSED  = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    logic [3:0]    r_rowMeta;
    logic [3:0]    r_rowSync;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_state;
    logic [1:0]    r_colIdx;
    logic [3:0]    r_col;
    logic [1:0]    r_latchRow;
    logic [SW-1:0] r_stable;
    logic          r_keyhit;
    logic [3:0]    r_keycode;
    logic          r_keyDown;

    logic          w_sample;
    logic          w_anyLow;
    logic [1:0]    w_rowIdx;
    logic [SW-1:0] w_stableNext;

    assign w_sample     = (r_dwell == DWELL_LAST);
    assign w_anyLow     = (r_rowSync != 4'hF);
    assign w_stableNext = (r_stable == STABLE_MAX) ? r_stable : r_stable + SW'(1);

    assign kp.col      = r_col;
    assign kp.keyhit   = r_keyhit;
    assign kp.keycode  = r_keycode;
    assign kp.key_down = r_keyDown;

    // Lowest-numbered low row wins when several rows are pulled down together.
    always_comb begin
        w_rowIdx = 2'd0;
        if (!r_rowSync[0])
            w_rowIdx = 2'd0;
        else if (!r_rowSync[1])
            w_rowIdx = 2'd1;
        else if (!r_rowSync[2])
            w_rowIdx = 2'd2;
        else if (!r_rowSync[3])
            w_rowIdx = 2'd3;
    end

    // Two-flop synchronizer for the asynchronous row returns; idles at all-high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rowMeta <= 4'hF;
            r_rowSync <= 4'hF;
        end else begin
            r_rowMeta <= kp.row;
            r_rowSync <= r_rowMeta;
        end
    end

    // Free-running dwell counter; its last count marks the sample cycle in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_dwell <= '0;
        else if (w_sample)
            r_dwell <= '0;
        else
            r_dwell <= r_dwell + DW'(1);
    end

    // Scan/debounce FSM with registered column drive and key-event outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_SCAN;
            r_colIdx   <= 2'd0;
            r_col      <= 4'b1110;
            r_latchRow <= 2'd0;
            r_stable   <= '0;
            r_keyhit   <= 1'b0;
            r_keycode  <= 4'h0;
            r_keyDown  <= 1'b0;
        end else begin
            r_keyhit <= 1'b0;
            if (w_sample) begin
                case (r_state)
                    S_SCAN: begin
                        if (w_anyLow) begin
                            r_latchRow <= w_rowIdx;
                            r_stable   <= SW'(1);
                            if (STABLE_ACCEPT == '0) begin
                                r_state   <= S_PRESSED;
                                r_keyhit  <= 1'b1;
                                r_keycode <= {w_rowIdx, r_colIdx};
                                r_keyDown <= 1'b1;
                            end else begin
                                r_state <= S_DEBOUNCE;
                            end
                        end else begin
                            r_colIdx <= r_colIdx + 2'd1;
                            r_col    <= {r_col[2:0], r_col[3]};
                        end
                    end
                    S_DEBOUNCE: begin
                        if (w_anyLow && (w_rowIdx == r_latchRow)) begin
                            if (r_stable >= STABLE_ACCEPT) begin
                                r_state   <= S_PRESSED;
                                r_keyhit  <= 1'b1;
                                r_keycode <= {w_rowIdx, r_colIdx};
                                r_keyDown <= 1'b1;
                            end
                            r_stable <= w_stableNext;
                        end else begin
                            r_state  <= S_SCAN;
                            r_colIdx <= r_colIdx + 2'd1;
                            r_col    <= {r_col[2:0], r_col[3]};
                        end
                    end
                    S_PRESSED: begin
                        if (!w_anyLow) begin
                            r_state  <= S_RELEASE;
                            r_stable <= SW'(1);
                        end
                    end
                    default: begin
                        if (!w_anyLow) begin
                            if (r_stable >= STABLE_ACCEPT) begin
                                r_state   <= S_SCAN;
                                r_keyDown <= 1'b0;
                                r_colIdx  <= r_colIdx + 2'd1;
                                r_col     <= {r_col[2:0], r_col[3]};
                            end
                            r_stable <= w_stableNext;
                        end else begin
                            r_state <= S_PRESSED;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model pulls rows low for
// pressed keys on the driven column; expected key codes go through a scoreboard.
module tb_keypad_scanner;

    localparam int SC = 8;
    localparam int DS = 3;

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  code;
        int          col;
    } vec_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] keys  = '0;
    logic [3:0]  rowModel;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int base       = 0;
    int hitCount   = 0;
    int lastHitRel = -1;

    logic [3:0] expQ[$];
    vec_t       vecs[6];

    keypad_scanner_if kpIf();

    keypad_scanner #(
        .SCAN_CYCLES      (SC),
        .DEBOUNCE_SAMPLES (DS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kpIf)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Absolute cycle counter; tests measure time relative to the last reset release.
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix model: a pressed key (r,c) pulls row r low while column c is driven.
    always_comb begin
        rowModel = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kpIf.col[c])
                    rowModel[r] = 1'b0;
    end
    assign kpIf.row = rowModel;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Scoreboard consumer: every keyhit pops one expected code.
    always @(negedge clk) begin
        if (!reset && kpIf.keyhit === 1'b1) begin
            logic [3:0] expCode;
            hitCount++;
            lastHitRel = cyc - base;
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_keyhit: got pulse at rel cycle %0d, required none", cyc - base);
            end else begin
                expCode = expQ.pop_front();
                checkOutput("keycode", {28'd0, kpIf.keycode}, {28'd0, expCode});
                checkOutput("key_down_at_hit", {31'd0, kpIf.key_down}, 32'd1);
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] k, input bit expectHit, input logic [3:0] code);
        keys = k;
        if (expectHit) expQ.push_back(code);
    endtask

    task automatic doReset();
        #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_col", {28'd0, kpIf.col}, 32'hE);
        checkOutput("reset_keyhit", {31'd0, kpIf.keyhit}, 32'd0);
        checkOutput("reset_keycode", {28'd0, kpIf.keycode}, 32'd0);
        checkOutput("reset_key_down", {31'd0, kpIf.key_down}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        base  = cyc;
    endtask

    task automatic waitRel(input int n);
        while ((cyc - base) < n) @(negedge clk);
    endtask

    task automatic waitHit(input int startCount, input int bound);
        while (hitCount == startCount && (cyc - base) < bound) @(negedge clk);
        if (hitCount == startCount) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL hit_timeout: got no keyhit by rel cycle %0d, required one", bound);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int h0;
        int c;
        logic [3:0] colStep[5];
        int         colTime[5];

        vecs[0] = '{16'h0200, 4'd9,  1};
        vecs[1] = '{16'h0001, 4'd0,  0};
        vecs[2] = '{16'h8000, 4'd15, 3};
        vecs[3] = '{16'h1010, 4'd4,  0};
        vecs[4] = '{16'h0840, 4'd6,  2};
        vecs[5] = '{16'h2080, 4'd13, 1};

        // Idle scan: column walks every SC cycles, nothing is reported.
        $display("[TB] idle scan");
        colStep = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        colTime = '{7, 8, 20, 28, 36};
        doReset();
        h0 = hitCount;
        waitRel(4);
        checkOutput("idle_col_start", {28'd0, kpIf.col}, 32'hE);
        for (int i = 0; i < 5; i++) begin
            waitRel(colTime[i]);
            checkOutput("idle_col", {28'd0, kpIf.col}, {28'd0, (i == 0) ? 4'b1110 : colStep[i]});
        end
        checkOutput("idle_key_down", {31'd0, kpIf.key_down}, 32'd0);
        checkOutput("idle_hits", hitCount - h0, 32'd0);

        // Table-driven presses: code, press latency, release timing and column advance.
        for (int v = 0; v < 6; v++) begin
            $display("[TB] vector %0d keys=%04h", v, vecs[v].keys);
            c = vecs[v].col;
            doReset();
            waitRel(2);
            h0 = hitCount;
            applyStimulus(vecs[v].keys, 1'b1, vecs[v].code);
            waitHit(h0, 8*c + 40);
            checkOutput("hit_cycle", lastHitRel, 8*c + 24);
            waitRel(8*c + 26);
            checkOutput("held_col", {28'd0, kpIf.col}, {28'd0, 4'b1111 ^ (4'b0001 << c)});
            applyStimulus('0, 1'b0, 4'h0);
            waitRel(8*c + 47);
            checkOutput("key_down_before_fall", {31'd0, kpIf.key_down}, 32'd1);
            waitRel(8*c + 48);
            checkOutput("key_down_fall", {31'd0, kpIf.key_down}, 32'd0);
            checkOutput("col_after_release", {28'd0, kpIf.col}, {28'd0, 4'b1111 ^ (4'b0001 << ((c + 1) % 4))});
            checkOutput("vector_hits", hitCount - h0, 32'd1);
        end

        // Bounce: row low for a single sample must not produce a press.
        $display("[TB] bounce");
        doReset();
        h0 = hitCount;
        waitRel(12);
        applyStimulus(16'h0002, 1'b0, 4'h0);
        waitRel(16);
        applyStimulus('0, 1'b0, 4'h0);
        waitRel(20);
        checkOutput("bounce_col_held", {28'd0, kpIf.col}, 32'hD);
        waitRel(24);
        checkOutput("bounce_col_adv", {28'd0, kpIf.col}, 32'hB);
        waitRel(40);
        checkOutput("bounce_col_wrap", {28'd0, kpIf.col}, 32'hE);
        checkOutput("bounce_hits", hitCount - h0, 32'd0);

        // Long hold, then a release interrupted by one low glitch, then a clean release.
        $display("[TB] hold and glitchy release");
        doReset();
        waitRel(2);
        h0 = hitCount;
        applyStimulus(16'h0200, 1'b1, 4'd9);
        waitHit(h0, 60);
        checkOutput("hold_hit_cycle", lastHitRel, 32);
        waitRel(1032);
        checkOutput("hold_key_down", {31'd0, kpIf.key_down}, 32'd1);
        checkOutput("hold_col", {28'd0, kpIf.col}, 32'hD);
        waitRel(1034);
        applyStimulus('0, 1'b0, 4'h0);
        waitRel(1050);
        checkOutput("glitch_key_down_a", {31'd0, kpIf.key_down}, 32'd1);
        applyStimulus(16'h0200, 1'b0, 4'h0);
        waitRel(1056);
        applyStimulus('0, 1'b0, 4'h0);
        waitRel(1072);
        checkOutput("glitch_key_down_b", {31'd0, kpIf.key_down}, 32'd1);
        waitRel(1079);
        checkOutput("glitch_key_down_c", {31'd0, kpIf.key_down}, 32'd1);
        waitRel(1080);
        checkOutput("glitch_key_down_fall", {31'd0, kpIf.key_down}, 32'd0);
        checkOutput("glitch_col_adv", {28'd0, kpIf.col}, 32'hB);
        checkOutput("glitch_hits", hitCount - h0, 32'd1);

        // Reset while a key is held: outputs clear at once, key is re-qualified from scratch.
        $display("[TB] reset during press");
        doReset();
        waitRel(2);
        h0 = hitCount;
        applyStimulus(16'h0010, 1'b1, 4'd4);
        waitHit(h0, 50);
        checkOutput("rst_first_hit", lastHitRel, 24);
        waitRel(40);
        checkOutput("rst_pre_key_down", {31'd0, kpIf.key_down}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_col", {28'd0, kpIf.col}, 32'hE);
        checkOutput("rst_mid_key_down", {31'd0, kpIf.key_down}, 32'd0);
        checkOutput("rst_mid_keycode", {28'd0, kpIf.keycode}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        base  = cyc;
        h0 = hitCount;
        applyStimulus(16'h0010, 1'b1, 4'd4);
        waitRel(20);
        checkOutput("rst_no_early_hit", hitCount - h0, 32'd0);
        waitHit(h0, 40);
        checkOutput("rst_second_hit", lastHitRel, 24);
        applyStimulus('0, 1'b0, 4'h0);
        waitRel(60);

        checkOutput("scoreboard_empty", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad, synchronizes and debounces the row returns, and reports each new key press as a single-cycle `keyhit` pulse with a 4-bit key code. It sits directly upstream of the key-lockout delay stage: `keyhit` feeds that stage's `keyhit` input, and `keycode` is consumed by the command decoder. Exactly one press event is produced per physical press, regardless of hold time.

## Interface
- `SCAN_CYCLES`, 50000: clk cycles each column is driven (dwell); 1 ms at 50 MHz; must be ≥ 4.
- `DEBOUNCE_SAMPLES`, 5: consecutive matching samples required to accept a press or release; must be ≥ 1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `row`  in  4  keypad row returns, active-low (pulled up off-chip), asynchronous to clk.
- `col`  out  4  column drives, active-low, exactly one bit low at all times.
- `keyhit`  out  1  one-cycle pulse per accepted press.
- `keycode`  out  4  code of last accepted key = {row_idx[1:0], col_idx[1:0]}; holds until next press.
- `key_down`  out  1  high from accepted press until accepted release.

## Operation
- `row` passes through a 2-flop synchronizer; all decisions use the synchronized value `row_s`.
- Dwell counter `dwell` runs 0..SCAN_CYCLES-1, wraps, and runs in every state. A "sample" is the cycle with `dwell == SCAN_CYCLES-1`; all state changes occur only on samples.
- `row_idx` = index of the lowest-numbered low bit of `row_s`; "any_low" = `row_s != 4'hF`. With multiple rows low, the lowest index wins.
- `col = ~(4'b0001 << col_idx)`. Advancing the column means `col_idx` wraps 3 -> 0; `dwell` is not reset.
- States:
  - SCAN: on sample, if any_low, latch `row_idx`, set `stable = 1`, and go to DEBOUNCE (or straight to PRESSED if DEBOUNCE_SAMPLES == 1). Otherwise advance the column.
  - DEBOUNCE: column is held. On sample, if any_low and `row_idx` matches the latched value, increment `stable`; when `stable` reaches DEBOUNCE_SAMPLES, go to PRESSED. Otherwise go to SCAN and advance the column.
  - PRESSED: column is held. On entry, pulse `keyhit`, load `keycode`, and set `key_down`. On sample, if `row_s == 4'hF`, go to RELEASE with `stable = 1`. Other keys are ignored.
  - RELEASE: column is held. On sample, if `row_s == 4'hF`, increment `stable`; at DEBOUNCE_SAMPLES, go to SCAN, clear `key_down`, and advance the column. If any_low, return to PRESSED with no new `keyhit`.
- Counter widths: `dwell` is `$clog2(SCAN_CYCLES)` bits; `stable` is `$clog2(DEBOUNCE_SAMPLES+1)` bits and saturates.

## Timing
- Reset (async assert, sync release behaviour irrelevant):
  - `col = 4'b1110`, `keyhit = 0`, `keycode = 4'h0`, `key_down = 0`.
  - State is SCAN; `dwell`, `stable`, `col_idx`, and the synchronizer flops are reset (synchronizer to 4'hF).
- All outputs are registered.
- `col` changes on the clk edge that ends a sample cycle. `row` settles within dwell because SCAN_CYCLES ≥ 4 covers the 2-cycle synchronizer latency.
- `keyhit`, the new `keycode`, and `key_down` rise together, one cycle after the accepting sample. `keyhit` is high for exactly 1 cycle.
- Press-to-`keyhit` latency after `row_s` is stable on the driven column: (DEBOUNCE_SAMPLES-1)·SCAN_CYCLES + 1 cycles from the first qualifying sample.
- `key_down` falls one cycle after the DEBOUNCE_SAMPLES-th consecutive all-high sample in RELEASE.
- Reset asserted mid-press forces the reset values immediately. No `keyhit` is produced after release of reset until a fresh debounced press.

## Test plan
(Use SCAN_CYCLES=8, DEBOUNCE_SAMPLES=3 throughout.)
- Reset, `row = 4'hF` -> reset values hold; `col` steps 1110, 1101, 1011, 0111, 1110, changing every 8 cycles; `keyhit` never asserts.
- Drive row2 low while `col == 1101`, held -> exactly one `keyhit` pulse 17 cycles after the first sample; `keycode = 4'd9`; `key_down = 1`; `col` stays 1101.
- Row low for one sample only (bounce) -> no `keyhit`; FSM returns to SCAN and `col` advances to 1011 after that sample.
- Hold key 1000 cycles, then release with one low glitch after 2 high samples, then a clean release -> one `keyhit` total; `key_down` falls 1 cycle after the 3rd consecutive high sample; `col` advances.
- Rows 1 and 3 low together on col0 -> `keycode = 4'd4` (row1 wins).
- Assert `reset` for 1 cycle during PRESSED -> `key_down = 0` and `col = 1110` immediately; after release of `reset` with the key still held, a new debounced `keyhit` appears only when col0 is scanned again and the key is re-qualified.
